// File: rtl/mem_pkg.sv
// Shared constants and types for the data-memory subsystem.
package mem_pkg;

  // Memory-mapped peripheral word addresses
  localparam logic [31:0] LED_ADDR     = 32'h0000_0400;
  localparam logic [31:0] CYCLE_ADDR   = 32'h0000_0404;
  localparam logic [31:0] TX_DATA_ADDR = 32'h0000_0408;
  localparam logic [31:0] TX_STAT_ADDR = 32'h0000_040C;

  // Clocks per serial bit time (e.g. 50 MHz / 115200 baud)
  localparam int unsigned BAUD_DIV_DEFAULT = 434;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

endpackage

// File: rtl/dmem_subsys_if.sv
// Core-side load/store bus of the data-memory subsystem.
interface dmem_subsys_if;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (
    output MemWrite,
    output ALUResult,
    output WriteData,
    input  ReadData
  );

  modport slave (
    input  MemWrite,
    input  ALUResult,
    input  WriteData,
    output ReadData
  );
endinterface

// File: rtl/uart_tx.sv
// 8N1 serial transmitter with a registered tx line.
module uart_tx
  import mem_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned    CntW   = $clog2(BAUD_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(BAUD_DIV - 1);

  tx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      data_q, data_d;
  logic            tx_q, tx_d;
  logic            bit_end;
  logic [2:0]      idx_next;

  assign bit_end  = (cnt_q == CntMax);
  assign idx_next = idx_q + 3'd1;

  // Next-state logic: tx_d is the line level for the bit that starts at the coming edge
  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    data_d  = data_q;
    tx_d    = tx_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (start) begin
          state_d = StStart;
          data_d  = data;
          tx_d    = 1'b0;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          idx_d   = 3'd0;
          tx_d    = data_q[0];
        end
      end
      StData: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_next;
            tx_d  = data_q[idx_next];
          end
        end
      end
      StStop: begin
        if (bit_end) begin
          state_d = StIdle;
          tx_d    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset forces the line idle immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      data_q  <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != StIdle);

endmodule

// File: rtl/dmem_subsys.sv
// Data RAM plus LED, cycle counter and serial transmitter on one load/store bus.
module dmem_subsys
  import mem_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 64,
  parameter int unsigned BAUD_DIV  = BAUD_DIV_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_subsys_if.slave  bus,
  output logic [9:0]    led,
  output logic          tx,
  output logic          tx_busy
);

  localparam int unsigned AddrW = $clog2(RAM_WORDS);

  logic [31:0]      ram [RAM_WORDS];
  logic [31:0]      addr_w;
  logic [AddrW-1:0] ram_idx;
  logic             ram_hit;
  logic             tx_start;
  logic [9:0]       led_q;
  logic [31:0]      cycle_q;
  logic             unused_addr_lsb;

  // Byte offset is ignored: every access is a whole word
  assign addr_w          = {bus.ALUResult[31:2], 2'b00};
  assign unused_addr_lsb = ^bus.ALUResult[1:0];
  assign ram_idx         = bus.ALUResult[AddrW+1:2];
  assign ram_hit         = (bus.ALUResult[31:2] < 30'(RAM_WORDS));
  assign tx_start        = bus.MemWrite && (addr_w == TX_DATA_ADDR);

  // RAM write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (bus.MemWrite && ram_hit) begin
      ram[ram_idx] <= bus.WriteData;
    end
  end

  // LED register and free-running cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q   <= 10'd0;
      cycle_q <= 32'd0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (bus.MemWrite && (addr_w == LED_ADDR)) begin
        led_q <= bus.WriteData[9:0];
      end
    end
  end

  // Combinational read mux; unmapped and write-only locations read zero
  always_comb begin
    bus.ReadData = 32'd0;
    if (ram_hit) begin
      bus.ReadData = ram[ram_idx];
    end else begin
      case (addr_w)
        LED_ADDR:     bus.ReadData = {22'd0, led_q};
        CYCLE_ADDR:   bus.ReadData = cycle_q;
        TX_STAT_ADDR: bus.ReadData = {31'd0, tx_busy};
        default:      bus.ReadData = 32'd0;
      endcase
    end
  end

  uart_tx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_uart_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .start (tx_start),
    .data  (bus.WriteData[7:0]),
    .tx    (tx),
    .busy  (tx_busy)
  );

  assign led = led_q;

endmodule

// File: tb/tb_dmem_subsys.sv
// Directed bench for dmem_subsys: vector table for bus accesses, hand sequences for
// counter wrap, serial framing, busy drops and asynchronous reset.
module tb_dmem_subsys;

  localparam int Baud = 4;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp_rd;
    logic [9:0]  exp_led;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [9:0] led;
  logic       tx;
  logic       tx_busy;
  int         n_vec = 0;
  int         n_bad = 0;

  dmem_subsys_if bus_if ();

  dmem_subsys #(
    .RAM_WORDS (64),
    .BAUD_DIV  (Baud)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus_if.slave),
    .led     (led),
    .tx      (tx),
    .tx_busy (tx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_tx(input logic [7:0] b, input int k);
    if (k < Baud) return 1'b0;
    if (k < 9 * Baud) return b[(k - Baud) / Baud];
    return 1'b1;
  endfunction

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus_if.MemWrite  = we;
    bus_if.ALUResult = addr;
    bus_if.WriteData = wdata;
  endtask

  vec_t vecs[$];

  initial begin
    drive(1'b0, 32'h0, 32'h0);
    #1 rst_n = 1'b0;

    // Reset values while held in reset
    repeat (2) @(negedge clk);
    drive(1'b0, 32'h404, 32'h0);
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_led", 32'(led), 32'd0);
    check("rst_cycle", bus_if.ReadData, 32'd0);

    // Release between edges; a write to CYCLE must be ignored
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'h404, 32'h0000_FFFF);
    #1 check("cycle_0", bus_if.ReadData, 32'd0);
    @(negedge clk);
    drive(1'b0, 32'h404, 32'h0);
    #1 check("cycle_1", bus_if.ReadData, 32'd1);
    @(negedge clk);
    #1 check("cycle_2", bus_if.ReadData, 32'd2);

    //            we    addr         wdata          chk   exp_rd         led
    vecs.push_back('{1'b1, 32'h000, 32'h0000_0000, 1'b0, 32'h0,         10'h000});
    vecs.push_back('{1'b1, 32'h014, 32'h1234_5678, 1'b0, 32'h0,         10'h000});
    vecs.push_back('{1'b1, 32'h010, 32'h1111_1111, 1'b0, 32'h0,         10'h000});
    vecs.push_back('{1'b1, 32'h010, 32'hDEAD_BEEF, 1'b1, 32'h1111_1111, 10'h000});
    vecs.push_back('{1'b0, 32'h010, 32'h0,         1'b1, 32'hDEAD_BEEF, 10'h000});
    vecs.push_back('{1'b0, 32'h013, 32'h0,         1'b1, 32'hDEAD_BEEF, 10'h000});
    vecs.push_back('{1'b0, 32'h014, 32'h0,         1'b1, 32'h1234_5678, 10'h000});
    vecs.push_back('{1'b1, 32'h0FC, 32'hA5A5_A5A5, 1'b0, 32'h0,         10'h000});
    vecs.push_back('{1'b0, 32'h0FC, 32'h0,         1'b1, 32'hA5A5_A5A5, 10'h000});
    vecs.push_back('{1'b0, 32'h100, 32'h0,         1'b1, 32'h0,         10'h000});
    vecs.push_back('{1'b1, 32'h400, 32'hFFFF_FFFF, 1'b1, 32'h0,         10'h000});
    vecs.push_back('{1'b0, 32'h400, 32'h0,         1'b1, 32'h0000_03FF, 10'h3FF});
    vecs.push_back('{1'b0, 32'h402, 32'h0,         1'b1, 32'h0000_03FF, 10'h3FF});
    vecs.push_back('{1'b0, 32'h408, 32'h0,         1'b1, 32'h0,         10'h3FF});
    vecs.push_back('{1'b0, 32'h40C, 32'h0,         1'b1, 32'h0,         10'h3FF});
    vecs.push_back('{1'b1, 32'h800, 32'hCAFE_F00D, 1'b1, 32'h0,         10'h3FF});
    vecs.push_back('{1'b0, 32'h800, 32'h0,         1'b1, 32'h0,         10'h3FF});
    vecs.push_back('{1'b0, 32'h000, 32'h0,         1'b1, 32'h0,         10'h3FF});
    vecs.push_back('{1'b1, 32'h400, 32'h0000_0155, 1'b1, 32'h0000_03FF, 10'h3FF});
    vecs.push_back('{1'b0, 32'h400, 32'h0,         1'b1, 32'h0000_0155, 10'h155});

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].addr, vecs[i].wdata);
      #1;
      if (vecs[i].chk) check($sformatf("vec%0d_rd", i), bus_if.ReadData, vecs[i].exp_rd);
      check($sformatf("vec%0d_led", i), 32'(led), 32'(vecs[i].exp_led));
    end

    // Counter wrap
    @(negedge clk);
    drive(1'b0, 32'h404, 32'h0);
    force dut.cycle_q = 32'hFFFF_FFFE;
    #1 check("wrap_fe", bus_if.ReadData, 32'hFFFF_FFFE);
    release dut.cycle_q;
    @(negedge clk);
    #1 check("wrap_ff", bus_if.ReadData, 32'hFFFF_FFFF);
    @(negedge clk);
    #1 check("wrap_00", bus_if.ReadData, 32'h0000_0000);

    // Frame 0x5A with a mid-frame drop and a last-STOP-cycle drop
    @(negedge clk);
    drive(1'b1, 32'h408, 32'h0000_005A);
    #1 check("pre_busy", 32'(tx_busy), 32'd0);
    for (int k = 0; k < 10 * Baud; k++) begin
      @(negedge clk);
      if (k == 10 || k == 10 * Baud - 1) drive(1'b1, 32'h408, 32'h0000_0033);
      else drive(1'b0, 32'h40C, 32'h0);
      #1;
      check($sformatf("f1_tx_k%0d", k), 32'(tx), 32'(exp_tx(8'h5A, k)));
      check($sformatf("f1_busy_k%0d", k), 32'(tx_busy), 32'd1);
      if (!bus_if.MemWrite) check($sformatf("f1_stat_k%0d", k), bus_if.ReadData, 32'd1);
    end

    // First idle cycle: accept a new frame with no gap
    @(negedge clk);
    drive(1'b1, 32'h408, 32'h0000_0033);
    #1;
    check("gap_busy", 32'(tx_busy), 32'd0);
    check("gap_tx", 32'(tx), 32'd1);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      drive(1'b0, 32'h40C, 32'h0);
      #1;
      check($sformatf("f2_tx_k%0d", k), 32'(tx), 32'(exp_tx(8'h33, k)));
      check($sformatf("f2_busy_k%0d", k), 32'(tx_busy), 32'd1);
    end

    // Asynchronous reset in DATA, between edges
    #1 rst_n = 1'b0;
    #1;
    check("arst_tx", 32'(tx), 32'd1);
    check("arst_busy", 32'(tx_busy), 32'd0);
    check("arst_led", 32'(led), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 32'h010, 32'h0);
    #1;
    check("post_tx", 32'(tx), 32'd1);
    check("post_ram", bus_if.ReadData, 32'hDEAD_BEEF);
    @(negedge clk);
    #1 check("post_idle_busy", 32'(tx_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_subsys.md
DMEM_SUBSYS -- requirements
Module: dmem_subsys

Interface
REQ-001 Parameter RAM_WORDS, default 64, number of 32-bit data RAM words; power of two.
REQ-002 Parameter BAUD_DIV, default 434, clock cycles per serial bit time; at least 2.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  system reset; one clock, reset is asynchronous and active-low.
REQ-005 MemWrite  input  1  store strobe from the processor core; sampled at the clk rising edge.
REQ-006 ALUResult  input  32  byte address from the core ALU.
REQ-007 WriteData  input  32  store data from the core.
REQ-008 ReadData  output  32  load data to the core; combinational in ALUResult.
REQ-009 led  output  10  memory-mapped LED register.
REQ-010 tx  output  1  8N1 serial transmit line; idles high.
REQ-011 tx_busy  output  1  high while a serial frame is in flight.

Function
REQ-012 Address decode SHALL ignore ALUResult[1:0]. All accesses are whole words.
REQ-013 The address map SHALL be as follows:
- RAM: 0x000 to (RAM_WORDS*4-1).
- LED: 0x400, read/write, bits [9:0].
- CYCLE: 0x404, read-only.
- TX_DATA: 0x408, write-only; reads return 0.
- TX_STATUS: 0x40C, read-only; bit0 is busy.
REQ-014 Unmapped addresses SHALL read 0x00000000, and writes to them SHALL be ignored.
REQ-015 A RAM write SHALL take effect at the rising edge where MemWrite=1. A read of the same word in the next cycle SHALL return the new data.
REQ-016 RAM reads SHALL be combinational. A same-cycle read of a word being written SHALL return the old data.
REQ-017 LED writes SHALL store WriteData[9:0]. Reads SHALL return the LED value zero-extended to 32 bits.
REQ-018 CYCLE SHALL be a 32-bit counter that increments every clock and wraps from 0xFFFFFFFF to 0. Writes to CYCLE SHALL be ignored.
REQ-019 The transmitter SHALL be a state machine with states IDLE, START, DATA, STOP. Each state lasts BAUD_DIV cycles per bit, and a 3-bit index selects the DATA bit.
REQ-020 State outputs and transitions:
- In IDLE, tx=1. A write to TX_DATA latches WriteData[7:0] and enters START at that edge.
- In START, tx=0, then go to DATA.
- In DATA, send the 8 data bits LSB first, then go to STOP.
- In STOP, tx=1, then go to IDLE.
REQ-021 tx_busy SHALL be 1 in every state except IDLE. The frame SHALL last exactly 10*BAUD_DIV cycles from the accepting edge.
REQ-022 A TX_DATA write while tx_busy=1 SHALL be dropped. This includes the final STOP cycle, and the latched byte SHALL NOT change.
REQ-023 A TX_DATA write in the first IDLE cycle after STOP SHALL be accepted, so back-to-back frames have no gap.
REQ-024 The tx output SHALL be driven from a register, so it has no combinational path from the inputs.

Reset
REQ-025 When rst_n is low, the following SHALL take their reset values immediately, without waiting for clk:
- led=0 and CYCLE=0.
- Transmitter state = IDLE, bit counter = 0, bit index = 0.
- tx=1 and tx_busy=0.
REQ-026 RAM contents SHALL NOT be reset.
REQ-027 Reset asserted mid-frame SHALL abort the frame, with tx high within the same cycle.
REQ-028 Reset SHALL release synchronously to clk. The first CYCLE increment SHALL occur at the first rising edge after release.

Structure
REQ-029 A shared package mem_pkg SHALL hold:
- The address constants: LED_ADDR, CYCLE_ADDR, TX_DATA_ADDR, TX_STAT_ADDR.
- The transmitter state enum.
- The default BAUD_DIV.
REQ-030 The transmitter SHALL be a separate sub-module uart_tx with ports:
- clk and rst_n.
- start (1 bit) and data (8 bits).
- tx and busy.
REQ-031 The RAM, the decode logic and the CYCLE counter SHALL live in dmem_subsys.

Verification
REQ-032 RAM test: write 0xDEADBEEF to 0x010, then read 0x010 and 0x013 in the next cycle. Both reads return 0xDEADBEEF, and 0x014 is unaffected.
REQ-033 LED and unmapped test: write 0xFFFFFFFF to 0x400. led=0x3FF, and a read of 0x400 returns 0x000003FF. A read of 0x800 returns 0.
REQ-034 Transmit test: BAUD_DIV=4, write 0x5A to 0x408.
- tx is 0 for 4 cycles, then the bits 0,1,0,1,1,0,1,0 for 4 cycles each, then 1 for 4 cycles.
- tx_busy is high for exactly 40 cycles.
- TX_STATUS reads 1 during the frame.
REQ-035 Busy drop test: write 0x33 mid-frame and again in the last STOP cycle. Both writes are dropped. A write of 0x33 in the first IDLE cycle starts a new frame immediately.
REQ-036 Counter wrap test: force CYCLE to 0xFFFFFFFE. Reads in consecutive cycles return 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
REQ-037 Async reset test: pull rst_n low between clock edges during DATA. tx=1, tx_busy=0 and led=0 before the next edge.
